mult_reg_sequencer: RTL

Sequencer for Thumb multiple-register instructions: PUSH, POP, STM and LDM. It sits between decode and the register-file/memory stages. It converts one multi-register instruction into a stream of single-register micro-ops, one per listed register, then an optional base-register writeback micro-op. Decode holds the instruction while busy_o is high.

---
 rtl/mult_reg_sequencer_if.sv | 33 +++
 rtl/mult_reg_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mult_reg_sequencer_if.sv
// rtl/mult_reg_sequencer_if.sv - decode-side and micro-op-side signal bundle for the multi-register sequencer
interface mult_reg_sequencer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int LIST_WIDTH = 8
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [LIST_WIDTH-1:0] reg_list_i;
    logic                  extra_reg_i;
    logic [ADDR_WIDTH-1:0] base_reg_i;
    logic                  uop_ready_i;
    logic                  busy_o;
    logic                  uop_valid_o;
    logic [ADDR_WIDTH-1:0] uop_reg_o;
    logic [ADDR_WIDTH-1:0] uop_base_o;
    logic [7:0]            uop_offset_o;
    logic                  uop_load_o;
    logic                  uop_wb_o;
    logic                  uop_last_o;
    logic                  done_o;

    modport slave (
        input  start_i, op_i, reg_list_i, extra_reg_i, base_reg_i, uop_ready_i,
        output busy_o, uop_valid_o, uop_reg_o, uop_base_o, uop_offset_o,
               uop_load_o, uop_wb_o, uop_last_o, done_o
    );

    modport master (
        output start_i, op_i, reg_list_i, extra_reg_i, base_reg_i, uop_ready_i,
        input  busy_o, uop_valid_o, uop_reg_o, uop_base_o, uop_offset_o,
               uop_load_o, uop_wb_o, uop_last_o, done_o
    );
endinterface

// File: rtl/mult_reg_sequencer.sv
// rtl/mult_reg_sequencer.sv - splits PUSH/POP/STM/LDM into single-register micro-ops plus base writeback
module mult_reg_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int LIST_WIDTH = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    mult_reg_sequencer_if.slave  bus
);
    localparam int MW = LIST_WIDTH + 1;
    localparam int CW = $clog2(MW + 1);
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_LDM  = 2'b11;
    localparam logic [ADDR_WIDTH-1:0] REG_SP = ADDR_WIDTH'(13);
    localparam logic [ADDR_WIDTH-1:0] REG_LR = ADDR_WIDTH'(14);
    localparam logic [ADDR_WIDTH-1:0] REG_PC = ADDR_WIDTH'(15);
    localparam logic [7:0] STEP = 8'(WORD_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WB} state_t;

    function automatic logic [CW-1:0] f_popcount(input logic [MW-1:0] m);
        f_popcount = '0;
        for (int i = 0; i < MW; i++) f_popcount = f_popcount + CW'(m[i]);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_lowest(input logic [MW-1:0] m);
        f_lowest = '0;
        for (int i = MW - 1; i >= 0; i--) if (m[i]) f_lowest = ADDR_WIDTH'(i);
    endfunction

    state_t                r_state, nxt_state;
    logic [1:0]            r_op, nxt_op;
    logic [ADDR_WIDTH-1:0] r_base, nxt_base;
    logic [MW-1:0]         r_mask, nxt_mask;
    logic [CW-1:0]         r_n, nxt_n;
    logic                  r_wb_en, nxt_wb_en;
    logic [7:0]            r_offset, nxt_offset;

    logic                  r_uop_valid, nxt_uop_valid;
    logic [ADDR_WIDTH-1:0] r_uop_reg, nxt_uop_reg;
    logic [ADDR_WIDTH-1:0] r_uop_base, nxt_uop_base;
    logic [7:0]            r_uop_offset, nxt_uop_offset;
    logic                  r_uop_load, nxt_uop_load;
    logic                  r_uop_wb, nxt_uop_wb;
    logic                  r_uop_last, nxt_uop_last;
    logic                  r_done, nxt_done;

    logic                  w_hs;
    logic [MW-1:0]         w_start_mask;
    logic [CW-1:0]         w_start_n;
    logic [7:0]            w_start_span;
    logic [LIST_WIDTH-1:0] w_list_shift;
    logic                  w_base_in_list;
    logic [MW-1:0]         w_mask_rest;
    logic [ADDR_WIDTH-1:0] w_low_idx;
    logic [7:0]            w_wb_span;

    assign w_hs           = r_uop_valid & bus.uop_ready_i;
    assign w_start_mask   = {bus.extra_reg_i & ~bus.op_i[1], bus.reg_list_i};
    assign w_start_n      = f_popcount(w_start_mask);
    assign w_start_span   = 8'(WORD_BYTES * int'(w_start_n));
    assign w_list_shift   = bus.reg_list_i >> bus.base_reg_i;
    assign w_base_in_list = w_list_shift[0];
    assign w_mask_rest    = r_mask & (r_mask - MW'(1));

    // Next-state: launch, per-uop mask/offset update, completion
    always_comb begin
        nxt_state  = r_state;
        nxt_op     = r_op;
        nxt_base   = r_base;
        nxt_mask   = r_mask;
        nxt_n      = r_n;
        nxt_wb_en  = r_wb_en;
        nxt_offset = r_offset;
        nxt_done   = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start_i) begin
                nxt_op     = bus.op_i;
                nxt_mask   = w_start_mask;
                nxt_base   = bus.op_i[1] ? bus.base_reg_i : REG_SP;
                nxt_n      = w_start_n;
                nxt_offset = (bus.op_i == OP_PUSH) ? -w_start_span : 8'd0;
                // LDM that reloads its own base must not have the loaded value overwritten
                nxt_wb_en  = (bus.op_i != OP_LDM) || !w_base_in_list;
                if (w_start_n == '0) nxt_done = 1'b1;
                else                 nxt_state = S_MEM;
            end
            S_MEM: if (w_hs) begin
                nxt_mask   = w_mask_rest;
                nxt_offset = r_offset + STEP;
                if (w_mask_rest == '0) begin
                    if (r_wb_en) nxt_state = S_WB;
                    else begin
                        nxt_state = S_IDLE;
                        nxt_done  = 1'b1;
                    end
                end
            end
            S_WB: if (w_hs) begin
                nxt_state = S_IDLE;
                nxt_done  = 1'b1;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    assign w_low_idx = f_lowest(nxt_mask);
    assign w_wb_span = 8'(WORD_BYTES * int'(nxt_n));

    // Micro-op fields for the coming cycle, derived from the next state so outputs can be registered
    always_comb begin
        nxt_uop_valid  = 1'b0;
        nxt_uop_reg    = '0;
        nxt_uop_base   = '0;
        nxt_uop_offset = '0;
        nxt_uop_load   = 1'b0;
        nxt_uop_wb     = 1'b0;
        nxt_uop_last   = 1'b0;
        if (nxt_state == S_MEM) begin
            nxt_uop_valid  = 1'b1;
            nxt_uop_reg    = (w_low_idx == ADDR_WIDTH'(LIST_WIDTH))
                           ? ((nxt_op == OP_POP) ? REG_PC : REG_LR) : w_low_idx;
            nxt_uop_base   = nxt_base;
            nxt_uop_offset = nxt_offset;
            nxt_uop_load   = nxt_op[0];
            nxt_uop_last   = !nxt_wb_en && ((nxt_mask & (nxt_mask - MW'(1))) == '0);
        end else if (nxt_state == S_WB) begin
            nxt_uop_valid  = 1'b1;
            nxt_uop_reg    = nxt_base;
            nxt_uop_base   = nxt_base;
            nxt_uop_offset = (nxt_op == OP_PUSH) ? -w_wb_span : w_wb_span;
            nxt_uop_wb     = 1'b1;
            nxt_uop_last   = 1'b1;
        end
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_base   <= '0;
            r_mask   <= '0;
            r_n      <= '0;
            r_wb_en  <= 1'b0;
            r_offset <= '0;
        end else begin
            r_state  <= nxt_state;
            r_op     <= nxt_op;
            r_base   <= nxt_base;
            r_mask   <= nxt_mask;
            r_n      <= nxt_n;
            r_wb_en  <= nxt_wb_en;
            r_offset <= nxt_offset;
        end
    end

    // Registered micro-op and done outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_uop_valid  <= 1'b0;
            r_uop_reg    <= '0;
            r_uop_base   <= '0;
            r_uop_offset <= '0;
            r_uop_load   <= 1'b0;
            r_uop_wb     <= 1'b0;
            r_uop_last   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_uop_valid  <= nxt_uop_valid;
            r_uop_reg    <= nxt_uop_reg;
            r_uop_base   <= nxt_uop_base;
            r_uop_offset <= nxt_uop_offset;
            r_uop_load   <= nxt_uop_load;
            r_uop_wb     <= nxt_uop_wb;
            r_uop_last   <= nxt_uop_last;
            r_done       <= nxt_done;
        end
    end

    assign bus.busy_o       = (r_state != S_IDLE);
    assign bus.uop_valid_o  = r_uop_valid;
    assign bus.uop_reg_o    = r_uop_reg;
    assign bus.uop_base_o   = r_uop_base;
    assign bus.uop_offset_o = r_uop_offset;
    assign bus.uop_load_o   = r_uop_load;
    assign bus.uop_wb_o     = r_uop_wb;
    assign bus.uop_last_o   = r_uop_last;
    assign bus.done_o       = r_done;
endmodule
